// File: rtl/dfm_spi_pkg.sv
// Shared types and constants for the host-side SPI link to the frequency meter.
// Command codes match the meter-side control path.
package dfm_spi_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    LOAD = 3'd2,
    DATA = 3'd3,
    HOLD = 3'd4,
    GAP  = 3'd5
  } spi_state_t;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  localparam int SPI_BYTE_BITS = 8;

  localparam logic [7:0] DFM_CMD_NOP         = 8'h00;
  localparam logic [7:0] DFM_CMD_START       = 8'h01;
  localparam logic [7:0] DFM_CMD_STATUS      = 8'h02;
  localparam logic [7:0] DFM_CMD_READ_RESULT = 8'h10;

  // States during which the chip select is held asserted.
  function automatic logic cs_active(input spi_state_t s);
    return (s == CMD) || (s == LOAD) || (s == DATA) || (s == HOLD);
  endfunction

endpackage

// File: rtl/dfm_spi_clkgen.sv
// Serial clock generator: counts CLK_DIV cycles per half period and toggles sclk.
// phase_end marks the last cycle of the current half period.
module dfm_spi_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic phase_end,
  output logic sclk
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign phase_end = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (en) begin
      if (cnt == LAST) begin
        cnt  <= '0;
        sclk <= ~sclk;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dfm_spi_master.sv
// SPI master, mode 0, MSB first: one command byte (dc=0) then len_i full-duplex data bytes (dc=1).
// Handshakes: a transfer is taken when valid and ready are both high at a clock edge; ready never waits on valid.
module dfm_spi_master
  import dfm_spi_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int LEN_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_vld_i,
  output logic                 cmd_rdy_o,
  input  logic [7:0]           cmd_byte_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  input  logic                 tx_vld_i,
  output logic                 tx_rdy_o,
  input  logic [7:0]           tx_data_i,
  output logic                 rx_vld_o,
  output logic [7:0]           rx_data_o,
  output logic                 busy_o,
  output logic                 spi_sclk_o,
  output logic                 spi_mosi_o,
  output logic                 spi_cs_n_o,
  input  logic                 spi_miso_i,
  output logic                 dc_o,
  output spi_state_t           state_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(CLK_DIV - 1);
  localparam logic [2:0] LAST_BIT = 3'(SPI_BYTE_BITS - 1);

  spi_state_t state, state_next;

  logic [LEN_WIDTH-1:0] rem;
  logic [2:0]           bit_cnt;
  logic [7:0]           tx_sh;
  logic [7:0]           rx_sh;
  logic [CW-1:0]        wait_cnt;
  logic                 phase_end;
  logic                 sclk;
  logic                 clk_en;
  logic                 bit_end;
  logic                 byte_end;
  logic                 accept;
  logic                 tx_hs;
  logic                 wait_last;

  assign clk_en    = (state == CMD) || (state == DATA);
  assign bit_end   = phase_end && sclk;
  assign byte_end  = bit_end && (bit_cnt == LAST_BIT);
  assign accept    = (state == IDLE) && cmd_vld_i;
  assign tx_hs     = (state == LOAD) && tx_vld_i;
  assign wait_last = (wait_cnt == WAIT_LAST);

  dfm_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk       (clk_i),
    .rst       (rst_i),
    .en        (clk_en),
    .clr       (~clk_en),
    .phase_end (phase_end),
    .sclk      (sclk)
  );

  assign spi_sclk_o = sclk;
  assign spi_mosi_o = tx_sh[7];
  assign state_o    = state;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (cmd_vld_i) state_next = CMD;
      CMD, DATA: if (byte_end) state_next = (rem == '0) ? HOLD : LOAD;
      LOAD:      if (tx_vld_i) state_next = DATA;
      HOLD:      if (wait_last) state_next = GAP;
      GAP:       if (wait_last) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      rem        <= '0;
      bit_cnt    <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      wait_cnt   <= '0;
      spi_cs_n_o <= 1'b1;
      dc_o       <= DC_CMD;
      cmd_rdy_o  <= 1'b1;
      busy_o     <= 1'b0;
      tx_rdy_o   <= 1'b0;
      rx_vld_o   <= 1'b0;
      rx_data_o  <= '0;
    end else begin
      state      <= state_next;
      spi_cs_n_o <= ~cs_active(state_next);
      cmd_rdy_o  <= (state_next == IDLE);
      busy_o     <= (state_next != IDLE);
      tx_rdy_o   <= (state_next == LOAD);
      rx_vld_o   <= 1'b0;

      if (state_next != state) wait_cnt <= '0;
      else if ((state == HOLD) || (state == GAP)) wait_cnt <= wait_cnt + 1'b1;

      if (accept) begin
        tx_sh   <= cmd_byte_i;
        rem     <= len_i;
        dc_o    <= DC_CMD;
        bit_cnt <= '0;
      end

      if (tx_hs) begin
        tx_sh   <= tx_data_i;
        rem     <= rem - 1'b1;
        dc_o    <= DC_DATA;
        bit_cnt <= '0;
      end

      // End of a high phase: sample miso and advance mosi to the next bit.
      if (bit_end) begin
        tx_sh   <= {tx_sh[6:0], 1'b0};
        rx_sh   <= {rx_sh[6:0], spi_miso_i};
        bit_cnt <= bit_cnt + 1'b1;
        if (byte_end && (state == DATA)) begin
          rx_vld_o  <= 1'b1;
          rx_data_o <= {rx_sh[6:0], spi_miso_i};
        end
      end
    end
  end

endmodule
